// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU stimulus generator.
//   - opcode constants, FSM state encoding, reset-phase operand constants
//   - alu_req_t: operand/opcode payload presented to the ALU
//   - lfsr_step / next_req / alu_model helpers
package alu_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned LFSR_W = 16;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_MUL = 2'd2;
    localparam logic [OP_W-1:0] OP_AND = 2'd3;

    localparam logic [OP_W-1:0]   RST_OP = 2'd2;
    localparam logic [DATA_W-1:0] RST_A  = 4'd2;
    localparam logic [DATA_W-1:0] RST_B  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSTSEQ = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Field order mirrors the LFSR slice: op=[9:8], b=[7:4], a=[3:0]
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } alu_req_t;

    // Fibonacci LFSR, taps 16,14,13,11, shift left, feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Operation payload taken from the LFSR value one step ahead of s
    function automatic alu_req_t next_req(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n = lfsr_step(s);
        return alu_req_t'(n[9:0]);
    endfunction

    // Expected ALU result, zero-extended operands, 8-bit wrap
    function automatic logic [RES_W-1:0] alu_model(input alu_req_t r);
        logic [RES_W-1:0] a8;
        logic [RES_W-1:0] b8;
        a8 = {4'd0, r.a};
        b8 = {4'd0, r.b};
        case (r.op)
            OP_ADD:  return a8 + b8;
            OP_SUB:  return a8 - b8;
            OP_MUL:  return a8 * b8;
            default: return a8 & b8;
        endcase
    endfunction

endpackage

// File: rtl/alu_lfsr16.sv
// 16-bit pseudo-random source for the stimulus generator.
//   clk, rst_n : clock, async active-low reset (state <= seed)
//   load_i     : reload seed (wins over step_i)
//   step_i     : advance one LFSR step
//   state_o    : current 16-bit LFSR state
module alu_lfsr16
    import alu_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] state_o
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Next-state selection
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/alu_stim_gen.sv
// Stimulus generator for the 4-bit registered ALU: holds the ALU in reset
// for RST_CYC cycles, then issues NUM_TXN pseudo-random operations, each
// held HOLD cycles on the operand/opcode outputs.
//   clk, rst        : clock, async active-low reset
//   start           : pulse, starts a run from IDLE or DONE
//   alu_out         : registered ALU result
//   alu_rst         : active-high ALU reset
//   alu_A/B/opcode  : operation presented to the ALU
//   busy, done      : run status
//   txn_cnt         : operations fully issued in this run
//   err_cnt         : result mismatches (only with ALU_SELFCHK_EN defined)
// Build option: define ALU_SELFCHK_EN to add the result checker and err_cnt.
module alu_stim_gen
    import alu_pkg::*;
#(
    parameter int unsigned       NUM_TXN = 10,
    parameter int unsigned       HOLD    = 2,
    parameter int unsigned       RST_CYC = 2,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RES_W-1:0]  alu_out,
    output logic              alu_rst,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              busy,
    output logic              done,
    output logic [7:0]        txn_cnt
`ifdef ALU_SELFCHK_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned     CNT_W     = 16;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [7:0]       TXN_LAST  = 8'(NUM_TXN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       txn_q, txn_d;
    alu_req_t         req_q, req_d;
    logic             alu_rst_q, alu_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic              lfsr_load_c;
    logic              lfsr_step_c;
    logic [LFSR_W-1:0] lfsr_state;

`ifdef ALU_SELFCHK_EN
    logic [7:0] err_q, err_d;
`else
    logic unused_alu_out;
    assign unused_alu_out = ^alu_out;
`endif

    alu_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (lfsr_load_c),
        .step_i  (lfsr_step_c),
        .state_o (lfsr_state)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txn_d       = txn_q;
        req_d       = req_q;
        alu_rst_d   = alu_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;
`ifdef ALU_SELFCHK_EN
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RSTSEQ;
                    cnt_d       = '0;
                    txn_d       = '0;
                    req_d       = '{op: RST_OP, b: RST_B, a: RST_A};
                    alu_rst_d   = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    lfsr_load_c = 1'b1;
`ifdef ALU_SELFCHK_EN
                    err_d       = '0;
`endif
                end
            end

            ST_RSTSEQ: begin
                if (cnt_q == RST_LAST) begin
                    // Release the ALU together with the first operation
                    state_d     = ST_DRIVE;
                    cnt_d       = '0;
                    alu_rst_d   = 1'b0;
                    lfsr_step_c = 1'b1;
                    req_d       = next_req(lfsr_state);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    txn_d = txn_q + 8'd1;
`ifdef ALU_SELFCHK_EN
                    // ALU output reflects the held operands by the last hold cycle
                    if ((alu_out != alu_model(req_q)) && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
`endif
                    if (txn_q == TXN_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        lfsr_step_c = 1'b1;
                        req_d       = next_req(lfsr_state);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            txn_q     <= '0;
            req_q     <= '0;
            alu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_SELFCHK_EN
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            txn_q     <= txn_d;
            req_q     <= req_d;
            alu_rst_q <= alu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ALU_SELFCHK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign alu_rst    = alu_rst_q;
    assign alu_A      = req_q.a;
    assign alu_B      = req_q.b;
    assign alu_opcode = req_q.op;
    assign busy       = busy_q;
    assign done       = done_q;
    assign txn_cnt    = txn_q;
`ifdef ALU_SELFCHK_EN
    assign err_cnt    = err_q;
`endif

endmodule

// File: doc/alu_stim_gen.md
Name: alu_stim_gen

Overview:
- Initiator-side block that drives the 4-bit registered ALU (`alu`): it sequences reset, then issues a fixed number of pseudo-random operations, each held for a programmable number of cycles.
- Sits beside `alu` in on-board self-test and lab builds, replacing hand-written stimulus.
- Optionally checks the ALU result against an internal reference model.

Parameters:
- NUM_TXN, 10: number of operations issued per run (1..255).
- HOLD, 2: cycles each operation is held on alu_A/alu_B/alu_opcode (min 2, covers the ALU's 1-cycle registered latency).
- RST_CYC, 2: cycles alu_rst is held high after start (min 1).
- SEED, 16'hACE1: LFSR seed; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when idle or done.
- alu_out  in  8  registered result from the ALU.
- alu_rst  out  1  active-high reset to the ALU.
- alu_A  out  4  operand A.
- alu_B  out  4  operand B.
- alu_opcode  out  2  operation select.
- busy  out  1  high from the cycle after start until the run ends.
- done  out  1  high after the last operation, until the next start.
- txn_cnt  out  8  operations fully issued in the current run.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State IDLE, lfsr=SEED (0 becomes 16'h0001), alu_rst=1.
  - alu_A=0, alu_B=0, alu_opcode=0.
  - busy=0, done=0, txn_cnt=0, hold counter=0.
  - Reset mid-run aborts immediately; no partial run is resumed.
- FSM states: IDLE, RSTSEQ, DRIVE, DONE. All outputs are registered.
- IDLE:
  - alu_rst=1.
  - start=1 → RSTSEQ next cycle; busy=1, done=0, txn_cnt=0, lfsr reloaded with SEED.
- RSTSEQ:
  - alu_rst=1, alu_opcode=2, alu_A=2, alu_B=3, held RST_CYC cycles.
  - Then → DRIVE; alu_rst=0 in the same cycle the first operation is presented.
- DRIVE:
  - On entry and at each operation boundary, the LFSR advances one step.
  - Outputs load from the new value: alu_A=lfsr[3:0], alu_B=lfsr[7:4], alu_opcode=lfsr[9:8].
  - Values are held exactly HOLD cycles; txn_cnt increments on the last hold cycle.
  - When txn_cnt reaches NUM_TXN → DONE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift left; feedback into bit 0.
- DONE:
  - busy=0, done=1, alu_rst=0; last operands held; txn_cnt holds NUM_TXN.
  - start=1 → RSTSEQ (restart; same sequence, since SEED reloads).
- start while busy: ignored.
- start coincident with reset release: ignored (reset dominates).
- txn_cnt never wraps, because NUM_TXN ≤ 255.

Optional Feature:
- Macro ALU_SELFCHK_EN.
- Defined:
  - Adds output port err_cnt (8 bits).
  - Reference model: 0 → A+B; 1 → A−B (8-bit two's-complement wrap); 2 → A*B; 3 → A&B. All zero-extended to 8 bits.
  - On the last hold cycle of each operation, alu_out is compared with the model of the currently driven operands; each mismatch increments err_cnt.
  - err_cnt saturates at 255, clears on reset and on each start, and holds in DONE.
- Undefined: no err_cnt port and no comparator logic; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_AND=2'd3.
  - FSM state encoding.
  - Reset-phase constants RST_OP=2, RST_A=2, RST_B=3.
- One sub-module, alu_lfsr16: seed load, step enable, 16-bit state out.
- FSM, counters and checker stay in alu_stim_gen.

Test Plan:
1. Reset and start timing. Hold rst=0, then release; pulse start with NUM_TXN=3, HOLD=2, RST_CYC=2.
   - busy=1 one cycle after start.
   - alu_rst=1 with opcode=2/A=2/B=3 for 2 cycles.
   - 3 operations × 2 cycles, then done=1, busy=0, txn_cnt=3.
2. LFSR sequence. Default SEED=16'hACE1.
   - Each (alu_A, alu_B, alu_opcode) matches a software LFSR model step for all 10 operations.
   - Values are stable for exactly HOLD cycles.
3. Abort and restart.
   - Drive rst=0 mid-DRIVE at txn_cnt=4 → all outputs take reset values immediately; alu_rst=1.
   - Restart → identical sequence from operation 1.
   - start during busy → no effect on sequence or counts.
4. SEED=0 → sequence is identical to SEED=16'h0001; the LFSR never locks at zero.
5. Self-check (ALU_SELFCHK_EN):
   - Connect the real alu → err_cnt=0 at done.
   - Tie alu_out=8'h00 → err_cnt equals the number of operations whose model result is nonzero.
   - err_cnt clears on the next start.
